// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture path (FSM states,
// default frame geometry and output field widths).
package cam_pkg;

  localparam int CAM_H_BYTES_DEF = 1280;
  localparam int CAM_V_LINES_DEF = 480;
  localparam int CAM_PIX_W       = 16;
  localparam int CAM_X_W         = 11;
  localparam int CAM_Y_W         = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LINE,
    ST_GAP
  } cam_state_e;

endpackage

// File: rtl/cam_byte_pair.sv
// Pairs accepted camera bytes into 16-bit pixels and issues the registered
// pixel strobe, coordinates and start-of-frame pulse.
module cam_byte_pair
  import cam_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic                 i_odd,
  input  logic                 i_first,
  input  logic [7:0]           i_data,
  input  logic [CAM_X_W-1:0]   i_x,
  input  logic [CAM_Y_W-1:0]   i_y,
  output logic [CAM_PIX_W-1:0] o_pix_data,
  output logic                 o_pix_valid,
  output logic [CAM_X_W-1:0]   o_pix_x,
  output logic [CAM_Y_W-1:0]   o_pix_y,
  output logic                 o_sof
);

  logic [7:0]           r_hi;
  logic [CAM_PIX_W-1:0] r_pix_data;
  logic                 r_pix_valid;
  logic [CAM_X_W-1:0]   r_pix_x;
  logic [CAM_Y_W-1:0]   r_pix_y;
  logic                 r_sof;

  // An unpaired high byte is simply overwritten by the next line's byte 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi        <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_sof       <= 1'b0;
    end else begin
      r_pix_valid <= 1'b0;
      r_sof       <= 1'b0;
      if (i_we && !i_odd) begin
        r_hi <= i_data;
      end
      if (i_we && i_odd) begin
        r_pix_data  <= {r_hi, i_data};
        r_pix_valid <= 1'b1;
        r_pix_x     <= i_x;
        r_pix_y     <= i_y;
        r_sof       <= i_first;
      end
    end
  end

  assign o_pix_data  = r_pix_data;
  assign o_pix_valid = r_pix_valid;
  assign o_pix_x     = r_pix_x;
  assign o_pix_y     = r_pix_y;
  assign o_sof       = r_sof;

endmodule

// File: rtl/cam_capture.sv
// Camera byte-stream capture: frame FSM, line/byte counters and error tracking.
// Define CAM_CAPTURE_STATS_EN to add the frame_cnt/err_cnt statistics outputs.
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_BYTES = CAM_H_BYTES_DEF,
  parameter int V_LINES = CAM_V_LINES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           data_in,
  input  logic                 pixel_valid,
  input  logic                 frame_done,
  input  logic                 capture_en,
  output logic [CAM_PIX_W-1:0] pix_data,
  output logic                 pix_valid,
  output logic [CAM_X_W-1:0]   pix_x,
  output logic [CAM_Y_W-1:0]   pix_y,
  output logic                 sof,
  output logic                 eof,
  output logic                 frame_err
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          err_cnt
`endif
);

  localparam int BW = $clog2(H_BYTES + 1);
  localparam int LW = $clog2(V_LINES + 1);
  localparam logic [BW-1:0] HMAX    = BW'(H_BYTES);
  localparam logic [LW-1:0] LMAX    = LW'(V_LINES);
  localparam logic [LW-1:0] LMAX_M1 = LW'(V_LINES - 1);

  cam_state_e    r_state, w_next;
  logic          r_fd_d, r_eof, r_frame_err;
  logic [BW-1:0] r_byte_cnt, w_idx, w_idx_next;
  logic [LW-1:0] r_line_cnt, w_line;
  logic          w_fd_rise, w_in_frame, w_byte_in, w_in_range, w_byte_we;
  logic          w_overrun, w_line_end, w_line_short, w_line_full;
  logic          w_frame_end, w_frame_bad, w_err_set, w_first;

  // frame_done beats a simultaneous byte, so a rising edge blocks byte intake.
  assign w_fd_rise  = frame_done & ~r_fd_d;
  assign w_in_frame = (r_state == ST_LINE) || (r_state == ST_GAP);
  assign w_byte_in  = pixel_valid & ~w_fd_rise & (r_state != ST_IDLE);
  assign w_idx      = (r_state == ST_LINE) ? r_byte_cnt : '0;
  assign w_line     = (r_state == ST_ARMED) ? '0 : r_line_cnt;
  assign w_in_range = (w_idx < HMAX) && (w_line < LMAX);
  assign w_byte_we  = w_byte_in & w_in_range;
  assign w_overrun  = w_byte_in & ~w_in_range;
  assign w_idx_next = (w_idx == HMAX) ? w_idx : w_idx + BW'(1);
  assign w_first    = (w_idx == BW'(1)) && (w_line == '0);

  assign w_line_end   = (r_state == ST_LINE) & ~pixel_valid & ~w_fd_rise;
  assign w_line_short = w_line_end & (r_byte_cnt != HMAX);
  assign w_frame_end  = w_fd_rise & w_in_frame;

  // A complete line that ends exactly as frame_done rises has not been counted yet.
  assign w_line_full  = (r_state == ST_LINE) & ~pixel_valid & (r_byte_cnt == HMAX);
  assign w_frame_bad  = ((r_state == ST_LINE) & ~w_line_full)
                      | (w_line_full ? (r_line_cnt != LMAX_M1) : (r_line_cnt != LMAX));
  assign w_err_set    = w_overrun | w_line_short | (w_frame_end & w_frame_bad);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fd_rise && capture_en) w_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_fd_rise)        w_next = capture_en ? ST_ARMED : ST_IDLE;
        else if (pixel_valid) w_next = ST_LINE;
      end
      ST_LINE: begin
        if (w_fd_rise)         w_next = capture_en ? ST_ARMED : ST_IDLE;
        else if (!pixel_valid) w_next = ST_GAP;
      end
      ST_GAP: begin
        if (w_fd_rise)        w_next = capture_en ? ST_ARMED : ST_IDLE;
        else if (pixel_valid) w_next = ST_LINE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fd_d      <= 1'b0;
      r_eof       <= 1'b0;
      r_frame_err <= 1'b0;
      r_byte_cnt  <= '0;
      r_line_cnt  <= '0;
    end else begin
      r_fd_d <= frame_done;
      r_eof  <= w_frame_end;
      if (w_byte_in) begin
        r_byte_cnt <= w_idx_next;
      end
      if (w_byte_in && (r_state == ST_ARMED)) begin
        r_line_cnt <= '0;
      end else if (w_line_end && (r_line_cnt != LMAX)) begin
        r_line_cnt <= r_line_cnt + LW'(1);
      end
      if (w_err_set) begin
        r_frame_err <= 1'b1;
      end else if (w_byte_we && w_first) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  cam_byte_pair u_pair (
    .clk        (clk),
    .reset      (reset),
    .i_we       (w_byte_we),
    .i_odd      (w_idx[0]),
    .i_first    (w_first),
    .i_data     (data_in),
    .i_x        (CAM_X_W'(w_idx >> 1)),
    .i_y        (CAM_Y_W'(w_line)),
    .o_pix_data (pix_data),
    .o_pix_valid(pix_valid),
    .o_pix_x    (pix_x),
    .o_pix_y    (pix_y),
    .o_sof      (sof)
  );

  assign eof       = r_eof;
  assign frame_err = r_frame_err;

`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] r_frame_cnt, r_err_cnt;

  // Counted on the eof cycle, when frame_err already holds the frame's verdict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (r_eof) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
      if (r_frame_err && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture with an 8-byte x 3-line frame geometry.
// Stats outputs are checked when CAM_CAPTURE_STATS_EN is defined.
module tb_cam_capture;

  localparam int H = 8;
  localparam int V = 3;

  logic        clk;
  logic        reset;
  logic [7:0]  data_in;
  logic        pixel_valid;
  logic        frame_done;
  logic        capture_en;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        sof;
  logic        eof;
  logic        frame_err;
`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  cam_capture #(.H_BYTES(H), .V_LINES(V)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .pixel_valid(pixel_valid),
    .frame_done (frame_done),
    .capture_en (capture_en),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .sof        (sof),
    .eof        (eof),
    .frame_err  (frame_err)
`ifdef CAM_CAPTURE_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
    bit          s;
  } pix_t;

  pix_t        expPix[$];
  bit          expEof[$];
  int          testsRun = 0;
  int          failures = 0;
  int          pixSeen = 0;
  int          eofSeen = 0;
  int          expFrames = 0;
  int          expErrs = 0;
  logic [15:0] firstExp = '0;
  logic [15:0] sofData = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every strobe and every eof is matched against the model queues.
  always @(negedge clk) begin
    pix_t e;
    if (reset) begin
      if (pix_valid) begin
        pixSeen++;
        if (sof) sofData = pix_data;
        if (expPix.size() == 0) begin
          checkOutput("unexpected pix_valid", 32'd1, 32'd0);
        end else begin
          e = expPix.pop_front();
          checkOutput("pix_data", pix_data, e.d);
          checkOutput("pix_x", pix_x, e.x);
          checkOutput("pix_y", pix_y, e.y);
          checkOutput("sof", sof, e.s);
          if (e.s) checkOutput("frame_err clear at sof", frame_err, 32'd0);
        end
      end else if (sof) begin
        checkOutput("sof without pix_valid", 32'd1, 32'd0);
      end
      if (eof) begin
        eofSeen++;
        if (expEof.size() == 0) checkOutput("unexpected eof", 32'd1, 32'd0);
        else checkOutput("frame_err at eof", frame_err, expEof.pop_front());
      end
    end
  end

  // Drives one frame and predicts its pixels/eof from the line-length rules.
  task automatic applyStimulus(input int lens[4], input int nLines, input bit captured,
                               input bit abortLast, input int rstLen, input bit ceAtEnd,
                               input int expCount);
    logic [7:0] val;
    logic [7:0] prev;
    bit         bad;
    int         eff;
    val = 8'h01;
    prev = 8'h00;
    pixSeen = 0;
    eofSeen = 0;
    capture_en = ceAtEnd;
    bad = (nLines != V) || abortLast;
    for (int l = 0; l < nLines; l++) begin
      eff = (abortLast && l == nLines - 1) ? lens[l] - 1 : lens[l];
      if (eff != H) bad = 1'b1;
    end
    if (captured) begin
      expFrames++;
      if (bad) expErrs++;
    end
    for (int l = 0; l < nLines; l++) begin
      for (int b = 0; b < lens[l]; b++) begin
        @(posedge clk); #1;
        if (rstLen > 0 && l == 0) begin
          reset = (b >= rstLen);
          if (b < rstLen) begin
            expFrames = 0;
            expErrs = 0;
          end
        end
        data_in = val;
        pixel_valid = 1'b1;
        if (abortLast && l == nLines - 1 && b == lens[l] - 1) begin
          frame_done = 1'b1;
          if (captured) expEof.push_back(bad);
        end else if (captured && l < V && b < H && (b % 2) == 1) begin
          expPix.push_back('{d: {prev, val}, x: b / 2, y: l, s: (b == 1 && l == 0)});
          if (b == 1 && l == 0) firstExp = {prev, val};
        end
        prev = val;
        val++;
      end
      @(posedge clk); #1;
      reset = 1'b1;
      pixel_valid = 1'b0;
      data_in = 8'h00;
      @(posedge clk); #1;
    end
    if (!abortLast) begin
      frame_done = 1'b1;
      if (captured) expEof.push_back(bad);
    end
    repeat (2) @(posedge clk);
    #1 frame_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pixel count", pixSeen, expCount);
    checkOutput("eof count", eofSeen, {31'd0, captured});
    checkOutput("pending pixels", expPix.size(), 32'd0);
    checkOutput("pending eof", expEof.size(), 32'd0);
    expPix.delete();
    expEof.delete();
  endtask

  task automatic armPulse();
    @(posedge clk); #1 frame_done = 1'b1;
    @(posedge clk); #1 frame_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    data_in = 8'h00;
    pixel_valid = 1'b0;
    frame_done = 1'b0;
    capture_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset pix_valid", pix_valid, 32'd0);
    checkOutput("reset pix_data", pix_data, 32'd0);
    checkOutput("reset pix_x", pix_x, 32'd0);
    checkOutput("reset pix_y", pix_y, 32'd0);
    checkOutput("reset sof", sof, 32'd0);
    checkOutput("reset eof", eof, 32'd0);
    checkOutput("reset frame_err", frame_err, 32'd0);
    reset = 1'b1;
    armPulse();

    // Good frame, bad 7-byte line, good frame again.
    applyStimulus('{8, 8, 8, 0}, 3, 1'b1, 1'b0, 0, 1'b1, 12);
    checkOutput("model first pixel", firstExp, 32'h0102);
    checkOutput("dut first pixel", sofData, 32'h0102);
    checkOutput("frame_err after good frame", frame_err, 32'd0);
    applyStimulus('{8, 7, 8, 0}, 3, 1'b1, 1'b0, 0, 1'b1, 11);
    checkOutput("frame_err sticky", frame_err, 32'd1);
    applyStimulus('{8, 8, 8, 0}, 3, 1'b1, 1'b0, 0, 1'b1, 12);
    checkOutput("frame_err after recovery", frame_err, 32'd0);

    // frame_done collides with a byte of an incomplete third line.
    applyStimulus('{8, 8, 5, 0}, 3, 1'b1, 1'b1, 0, 1'b1, 10);
    checkOutput("frame_err after abort", frame_err, 32'd1);

    // Too many bytes in a line, then too many lines.
    applyStimulus('{10, 8, 8, 0}, 3, 1'b1, 1'b0, 0, 1'b1, 12);
    applyStimulus('{8, 8, 8, 8}, 4, 1'b1, 1'b0, 0, 1'b1, 12);
`ifdef CAM_CAPTURE_STATS_EN
    checkOutput("frame_cnt", frame_cnt, expFrames);
    checkOutput("err_cnt", err_cnt, expErrs);
`endif

    // Reset released mid-line: frame ignored, capture resumes after frame_done.
    applyStimulus('{8, 8, 8, 0}, 3, 1'b0, 1'b0, 3, 1'b1, 0);
    applyStimulus('{8, 8, 8, 0}, 3, 1'b1, 1'b0, 0, 1'b1, 12);

    // capture_en low at a boundary skips one frame; re-enabled mid-frame.
    applyStimulus('{8, 7, 8, 0}, 3, 1'b1, 1'b0, 0, 1'b0, 11);
    applyStimulus('{8, 8, 8, 0}, 3, 1'b0, 1'b0, 0, 1'b1, 0);
    applyStimulus('{8, 8, 8, 0}, 3, 1'b1, 1'b0, 0, 1'b1, 12);
    checkOutput("frame_err final", frame_err, 32'd0);
`ifdef CAM_CAPTURE_STATS_EN
    checkOutput("frame_cnt after reset", frame_cnt, 32'd3);
    checkOutput("err_cnt after reset", err_cnt, 32'd1);
    checkOutput("model frame count", expFrames, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
